// File: rtl/rdcla_pipe_if.sv
// Operand/result bundle for the pipelined prefix adder.
// The master drives operands and result backpressure; the slave (the adder) returns the handshake and the result.
interface rdcla_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rdcla_pipe.sv
// Pipelined Kogge-Stone adder/subtractor using kill/propagate/generate carry status.
// Stage 0 encodes the operands, stages 1..LAT-1 each double the resolved prefix span.
// A single advance signal moves or freezes the whole pipe, bubbles included.
module rdcla_pipe #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  rdcla_pipe_if.slave bus
);
  localparam int LAT  = $clog2(WIDTH) + 1;
  localparam int LAST = LAT - 1;

  if (WIDTH < 2 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "rdcla_pipe: WIDTH must be a power of two between 2 and 64");
  end

  // Carry status per position is (hi,lo): kill=(0,0), propagate=(1,0), generate=(1,1).
  // Position 0 holds the effective carry-in; operand bit i sits at position i+1.
  logic [LAST:0]            valid_q;
  logic [LAST:0][WIDTH:0]   hi_q, lo_q;
  logic [LAST:0][WIDTH:0]   hi_d, lo_d;
  logic [LAST:0][WIDTH-1:0] psum_q;
  logic [LAST:0]            amsb_q, bmsb_q;

  logic             advance;
  logic [WIDTH-1:0] beff;
  logic             ceff;
  logic             top_prop;
  logic             carry_out;

  assign advance      = !valid_q[LAST] || bus.out_ready;
  assign bus.in_ready = advance;

  assign beff = bus.sub ? ~bus.b : bus.b;
  assign ceff = bus.sub | bus.cin;

  // Next-state of every carry-status stage: encode at stage 0, prefix-combine at distance 2^(k-1) after that.
  always_comb begin
    // NOTE: whole arrays get a default before the loops so no bit can fall through and infer a latch.
    hi_d = '0;
    lo_d = '0;
    hi_d[0] = {bus.a | beff, ceff};
    lo_d[0] = {bus.a & beff, ceff};
    for (int k = 1; k < LAT; k++) begin
      hi_d[k] = hi_q[k-1];
      lo_d[k] = lo_q[k-1];
      for (int j = 1 << (k - 1); j <= WIDTH; j++) begin
        // A propagating upper group takes the status of the group below it; K or G stays as is.
        if (hi_q[k-1][j] && !lo_q[k-1][j]) begin
          hi_d[k][j] = hi_q[k-1][j - (1 << (k - 1))];
          lo_d[k][j] = lo_q[k-1][j - (1 << (k - 1))];
        end
      end
    end
  end

  // Pipeline registers: status, partial sum and operand MSBs all shift together or hold together.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: payload registers are reset too, because the result outputs must read zero while rst is high.
    if (rst) begin
      valid_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      psum_q  <= '0;
      amsb_q  <= '0;
      bmsb_q  <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage read the previous stage's old value in the same edge.
      valid_q <= {valid_q[LAST-1:0], bus.in_valid};
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      psum_q  <= {psum_q[LAST-1:0], bus.a ^ beff};
      amsb_q  <= {amsb_q[LAST-1:0], bus.a[WIDTH-1]};
      bmsb_q  <= {bmsb_q[LAST-1:0], beff[WIDTH-1]};
    end
  end

  // After LAT-1 combine stages position WIDTH has only resolved positions 1..WIDTH;
  // if that whole group propagates, the carry-out is the carry-in held at position 0.
  assign top_prop  = hi_q[LAST][WIDTH] & ~lo_q[LAST][WIDTH];
  assign carry_out = top_prop ? lo_q[LAST][0] : lo_q[LAST][WIDTH];

  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = psum_q[LAST] ^ lo_q[LAST][WIDTH-1:0];
  assign bus.cout      = carry_out;
  // Same-sign operands giving a different-sign result; identical to carry[WIDTH] ^ carry[WIDTH-1].
  assign bus.ovf       = (amsb_q[LAST] == bmsb_q[LAST]) && (bus.sum[WIDTH-1] != amsb_q[LAST]);

  // Every carry position below WIDTH must be fully resolved (K or G) when a result leaves.
  always_comb begin
    if (valid_q[LAST]) begin
      assert ((hi_q[LAST][WIDTH-1:0] & ~lo_q[LAST][WIDTH-1:0]) == '0);
    end
  end
endmodule

// File: tb/tb_rdcla_pipe.sv
// Directed and randomised checks of rdcla_pipe at WIDTH 2, 8, 32 and 64.
// One driver feeds all four instances; each instance has its own scoreboard and hold checker.
module tb_rdcla_pipe;
  localparam int WS [4] = '{2, 8, 32, 64};

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cin_t;
  logic        sub_t;
  logic [63:0] a_t;
  logic [63:0] b_t;

  int checks = 0;
  int errors = 0;
  int pend    [4];
  int out_cnt [4];
  int base    [4];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain unsigned and signed integer arithmetic at width w.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic        [65:0] mask, ua, ub, u;
    logic signed [66:0] sa, sb, r, lim;
    logic               ov;
    mask = (66'd1 << w) - 66'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    u    = sub ? (ua + (~ub & mask) + 66'd1) : (ua + ub + {65'd0, cin});
    sa   = $signed({1'b0, ua});
    sb   = $signed({1'b0, ub});
    if (ua[w-1]) sa = sa - (67'sd1 <<< w);
    if (ub[w-1]) sb = sb - (67'sd1 <<< w);
    r    = sub ? (sa - sb) : (sa + sb + $signed({66'd0, cin}));
    lim  = 67'sd1 <<< (w - 1);
    ov   = (r >= lim) || (r < -lim);
    return {ov, u[w], u[63:0] & mask[63:0]};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_w
    localparam int W = WS[g];
    rdcla_pipe_if #(.WIDTH(W)) bus ();
    rdcla_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;
    assign bus.a         = a_t[W-1:0];
    assign bus.b         = b_t[W-1:0];
    assign bus.cin       = cin_t;
    assign bus.sub       = sub_t;

    beat_t       q [$];
    beat_t       bt;
    logic [65:0] er;
    logic        hold_on;
    logic [W-1:0] hold_sum;
    logic        hold_cout;
    logic        hold_ovf;

    initial begin
      hold_on = 1'b0;
      out_cnt[g] = 0;
      pend[g] = 0;
    end

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        hold_on = 1'b0;
      end else begin
        if (hold_on) begin
          check($sformatf("w%0d_hold_valid", W), 64'(bus.out_valid), 64'(1));
          check($sformatf("w%0d_hold_sum", W), 64'(bus.sum), 64'(hold_sum));
          check($sformatf("w%0d_hold_cout", W), 64'(bus.cout), 64'(hold_cout));
          check($sformatf("w%0d_hold_ovf", W), 64'(bus.ovf), 64'(hold_ovf));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check($sformatf("w%0d_unexpected_beat", W), 64'(1), 64'(0));
          end else begin
            bt = q.pop_front();
            er = model(W, bt.a, bt.b, bt.cin, bt.sub);
            check($sformatf("w%0d_sb_sum", W), 64'(bus.sum), er[63:0]);
            check($sformatf("w%0d_sb_cout", W), 64'(bus.cout), 64'(er[64]));
            check($sformatf("w%0d_sb_ovf", W), 64'(bus.ovf), 64'(er[65]));
          end
          out_cnt[g]++;
        end
        if (bus.in_valid && bus.in_ready)
          q.push_back('{a: 64'(bus.a), b: 64'(bus.b), cin: bus.cin, sub: bus.sub});
        hold_on   = bus.out_valid && !bus.out_ready;
        hold_sum  = bus.sum;
        hold_cout = bus.cout;
        hold_ovf  = bus.ovf;
      end
      pend[g] = q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_t = '0; b_t = '0; cin_t = 1'b0; sub_t = 1'b0;

    // Reset is asynchronous: outputs are zero before any clock edge.
    #2;
    check("rst_w32_valid", 64'(g_w[2].bus.out_valid), 64'(0));
    check("rst_w32_sum", 64'(g_w[2].bus.sum), 64'(0));
    check("rst_w32_cout", 64'(g_w[2].bus.cout), 64'(0));
    check("rst_w32_ovf", 64'(g_w[2].bus.ovf), 64'(0));
    check("rst_w32_in_ready", 64'(g_w[2].bus.in_ready), 64'(1));
    check("rst_w8_valid", 64'(g_w[1].bus.out_valid), 64'(0));
    @(posedge clk); #2; rst = 1'b0;
    check("post_rst_in_ready", 64'(g_w[2].bus.in_ready), 64'(1));

    // 0x7F + 0x01: exact latency on the 8- and 32-bit instances.
    a_t = 64'h7F; b_t = 64'h01; cin_t = 1'b0; sub_t = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      check($sformatf("lat_w8_valid_n%0d", n), 64'(g_w[1].bus.out_valid), 64'(n == 4));
      check($sformatf("lat_w32_valid_n%0d", n), 64'(g_w[2].bus.out_valid), 64'(n == 6));
      if (n == 4) begin
        check("w8_7f_sum", 64'(g_w[1].bus.sum), 64'h80);
        check("w8_7f_cout", 64'(g_w[1].bus.cout), 64'(0));
        check("w8_7f_ovf", 64'(g_w[1].bus.ovf), 64'(1));
      end
      if (n == 6) begin
        check("w32_7f_sum", 64'(g_w[2].bus.sum), 64'h80);
        check("w32_7f_ovf", 64'(g_w[2].bus.ovf), 64'(0));
      end
      step();
    end

    // Subtraction both ways; cin is ignored when sub=1.
    a_t = 64'h05; b_t = 64'h07; cin_t = 1'b1; sub_t = 1'b1; in_valid = 1'b1;
    step();
    a_t = 64'h07; b_t = 64'h05; cin_t = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    check("w8_sub_lo_valid", 64'(g_w[1].bus.out_valid), 64'(1));
    check("w8_sub_lo_sum", 64'(g_w[1].bus.sum), 64'hFE);
    check("w8_sub_lo_cout", 64'(g_w[1].bus.cout), 64'(0));
    check("w8_sub_lo_ovf", 64'(g_w[1].bus.ovf), 64'(0));
    step();
    check("w8_sub_hi_valid", 64'(g_w[1].bus.out_valid), 64'(1));
    check("w8_sub_hi_sum", 64'(g_w[1].bus.sum), 64'h02);
    check("w8_sub_hi_cout", 64'(g_w[1].bus.cout), 64'(1));
    check("w8_sub_hi_ovf", 64'(g_w[1].bus.ovf), 64'(0));
    repeat (4) step();

    // Full carry ripple at 32 bits, then at 64 bits.
    a_t = 64'hFFFF_FFFF; b_t = '0; cin_t = 1'b1; sub_t = 1'b0; in_valid = 1'b1;
    step();
    a_t = '1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("w32_ripple_valid", 64'(g_w[2].bus.out_valid), 64'(1));
    check("w32_ripple_sum", 64'(g_w[2].bus.sum), 64'(0));
    check("w32_ripple_cout", 64'(g_w[2].bus.cout), 64'(1));
    check("w32_ripple_ovf", 64'(g_w[2].bus.ovf), 64'(0));
    repeat (2) step();
    check("w64_ripple_valid", 64'(g_w[3].bus.out_valid), 64'(1));
    check("w64_ripple_sum", 64'(g_w[3].bus.sum), 64'(0));
    check("w64_ripple_cout", 64'(g_w[3].bus.cout), 64'(1));
    check("w64_ripple_ovf", 64'(g_w[3].bus.ovf), 64'(0));
    cin_t = 1'b0;
    repeat (8) step();

    // Backpressure: 10 beats, out_ready low for three cycles mid-stream.
    base[2] = out_cnt[2];
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      a_t = {$urandom, $urandom}; b_t = {$urandom, $urandom};
      cin_t = 1'($urandom); sub_t = 1'($urandom); in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        out_ready = !(cyc >= 8 && cyc <= 10);
        #1;
        if (!out_ready) begin
          check($sformatf("bp_in_ready_c%0d", cyc), 64'(g_w[2].bus.in_ready), 64'(0));
          check($sformatf("bp_out_valid_c%0d", cyc), 64'(g_w[2].bus.out_valid), 64'(1));
        end
        acc = g_w[2].bus.in_ready;
        step();
        cyc++;
      end
      if (!acc) check("bp_accept_timeout", 64'(0), 64'(1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    check("bp_w32_result_count", 64'(out_cnt[2] - base[2]), 64'(10));

    // Reset mid-flight: three beats in, one result stalled at the 8-bit output.
    for (int i = 0; i < 3; i++) begin
      a_t = {$urandom, $urandom}; b_t = {$urandom, $urandom}; sub_t = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("midrst_w8_valid_before", 64'(g_w[1].bus.out_valid), 64'(1));
    #2; rst = 1'b1;
    #1;
    check("midrst_w8_valid_drop", 64'(g_w[1].bus.out_valid), 64'(0));
    check("midrst_w8_sum_zero", 64'(g_w[1].bus.sum), 64'(0));
    check("midrst_w8_cout_zero", 64'(g_w[1].bus.cout), 64'(0));
    check("midrst_w8_ovf_zero", 64'(g_w[1].bus.ovf), 64'(0));
    check("midrst_w8_in_ready", 64'(g_w[1].bus.in_ready), 64'(1));
    @(posedge clk); #2; rst = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      check($sformatf("postrst_w8_quiet_%0d", n), 64'(g_w[1].bus.out_valid), 64'(0));
      check($sformatf("postrst_w32_quiet_%0d", n), 64'(g_w[2].bus.out_valid), 64'(0));
    end
    a_t = 64'd3; b_t = 64'd4; cin_t = 1'b0; sub_t = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      check($sformatf("postrst_lat_w32_n%0d", n), 64'(g_w[2].bus.out_valid), 64'(n == 6));
      if (n == 6) check("postrst_w32_sum", 64'(g_w[2].bus.sum), 64'd7);
      step();
    end
    repeat (4) step();

    // Random regression with random in_valid and out_ready on every width.
    for (int k = 0; k < 4; k++) base[k] = out_cnt[k];
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a_t = pick(); b_t = pick();
      cin_t = 1'($urandom); sub_t = 1'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) step();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rand_w%0d_drained", WS[k]), 64'(pend[k]), 64'(0));
      check($sformatf("rand_w%0d_progress", WS[k]), 64'(out_cnt[k] - base[k] > 100), 64'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
